operand_pair_scheduler: RTL and testbench
=========================================

Name: operand_pair_scheduler

Overview:
- Sequencer between the sparse-cluster input stream and the MAC lane.
- Accepts one cluster per handshake: an 8-bit weight bitmask, an 8-bit activation bitmask and an end-of-dot-product flag.
- Walks the mutual (A&W) bitmask, issuing one matched operand pair per cycle as dense-cluster indices (idx_a, idx_w), with first/last/done markers.
- Replaces the one-shot packed-index result with a flow-controlled, back-pressurable pair stream, and keeps a per-dot-product pair counter.

Parameters:
- BITMASK_LENGTH, 8, bits per cluster bitmask.
- INDEX_BITWIDTH, 3, width of a dense index; equals clog2(BITMASK_LENGTH).
- ACC_COUNT_BITWIDTH, 16, width of the per-dot-product pair counter.

Ports:
- clock  in  1  single clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  cluster available.
- in_ready  out  1  scheduler accepts a cluster this cycle.
- in_bitmask_w  in  BITMASK_LENGTH  weight bitmask.
- in_bitmask_a  in  BITMASK_LENGTH  activation bitmask.
- in_last  in  1  cluster is the last of the dot product.
- out_valid  out  1  pair beat valid.
- out_ready  in  1  MAC accepts the beat.
- out_idx_a  out  INDEX_BITWIDTH  dense activation index of the pair.
- out_idx_w  out  INDEX_BITWIDTH  dense weight index of the pair.
- out_first  out  1  first beat of the cluster.
- out_last_pair  out  1  last beat of the cluster.
- out_nop  out  1  beat carries no pair; MAC must not multiply.
- out_acc_done  out  1  last beat of the dot product.
- out_acc_pairs  out  ACC_COUNT_BITWIDTH  total real pairs in the dot product; valid when out_acc_done.

Behaviour:
- Reset: clock and reset are one clock, reset asynchronous active-low (resetn), as already decided.
  - Asserting resetn=0 immediately clears state to IDLE.
  - out_valid, out_first, out_last_pair, out_nop, out_acc_done = 0; out_idx_a/w = 0.
  - Pair counter and out_acc_pairs = 0; in_ready = 0 while resetn=0.
  - Reset mid-cluster discards the remaining pairs; no partial beat follows deassertion.
- Handshakes: a transfer occurs when valid&ready on the rising edge. While out_valid=1 and out_ready=0, all out_* fields hold stable.
- FSM states:
  - IDLE: out_valid=0, in_ready=1.
  - ISSUE: holds the registered bitmask_a, bitmask_w, remaining mask rem = A&W, last flag and a first flag.
- On accept, load the registers; next state:
  - rem!=0 → ISSUE, out_first=1.
  - rem==0 and in_last=0 → cluster discarded, stay IDLE, no beat.
  - rem==0 and in_last=1 → ISSUE with a NOP beat: out_nop=1, out_first=1, out_last_pair=1, out_acc_done=1, idx=0.
- Latency: first beat is visible on out_valid the cycle after acceptance (registered outputs).
- Pair order: ascending bit position; bit 0 is issued first.
  - Current position p = lowest set bit of rem.
  - out_idx_a = popcount(bitmask_a[p-1:0]); out_idx_w = popcount(bitmask_w[p-1:0]).
  - Widths are INDEX_BITWIDTH, with no overflow possible.
- On each out handshake, clear bit p in rem.
  - out_last_pair = 1 when rem has exactly one set bit.
  - out_acc_done = out_last_pair & last flag.
- Back-to-back: in_ready = IDLE, or (ISSUE & out_ready & out_last_pair).
  - A cluster accepted in the same cycle as the last beat handshake loads directly, with no bubble.
  - An empty non-last cluster accepted in that cycle moves to IDLE.
- Pair counter:
  - Increments on each non-NOP out handshake; saturates at all-ones.
  - out_acc_pairs shows counter + current beat on the acc_done beat.
  - Counter clears to 0 after the acc_done handshake.
- Throughput: one pair per cycle when out_ready=1; a k-pair cluster occupies exactly k cycles.

Decomposition:
- Shared package: BITMASK_LENGTH, INDEX_BITWIDTH, ACC_COUNT_BITWIDTH constants, plus a pair-beat typedef (idx_a, idx_w, first, last_pair, nop, acc_done).
- One combinational sub-module, lsb_pair_picker. Inputs: rem, bitmask_a, bitmask_w. Outputs: p one-hot, idx_a, idx_w, rem_next, single_bit flag.
- FSM, registers and counter live in operand_pair_scheduler.

Test Plan:
- A=8'b1111_0101, W=8'b1010_1110, last=1, out_ready=1.
  - Expect 3 beats (a,w) = (1,1), (3,3), (5,4).
  - first on beat 1; last_pair and acc_done on beat 3; out_acc_pairs=3.
- Same cluster with out_ready=0 for 3 cycles on beat 2: (3,3) held stable 4 cycles, in_ready=0 throughout, then (5,4).
- Empty non-last cluster A=8'h0F, W=8'hF0, last=0, followed by A=W=8'h01, last=1.
  - Expect a single beat (0,0) with first, last_pair and acc_done; out_acc_pairs=1.
- A=8'h00, W=8'hFF, last=1: exactly one beat with out_nop=1, acc_done=1, out_acc_pairs=0.
- Two clusters A=W=8'hFF (last=0, then last=1) with in_valid held high.
  - 16 consecutive beats, idx 0..7 twice, no bubble; in_ready high only on beats 8 and 16.
  - acc_done on beat 16 with out_acc_pairs=16.
- resetn pulsed low during beat 4 of an 8'hFF cluster.
  - out_valid drops immediately.
  - After release: IDLE, in_ready=1, out_acc_pairs=0, no residual beats.

Source files
------------

// File: rtl/operand_pair_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// operand_pair_scheduler_pkg
// Shared constants, FSM state type, pair-beat record and a saturating
// increment helper for the operand pair scheduler.
// ----------------------------------------------------------------------------
package operand_pair_scheduler_pkg;

    localparam int unsigned BITMASK_LENGTH     = 8;
    localparam int unsigned INDEX_BITWIDTH     = 3;   // clog2(BITMASK_LENGTH)
    localparam int unsigned ACC_COUNT_BITWIDTH = 16;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_t;

    typedef struct packed {
        logic [INDEX_BITWIDTH-1:0] idx_a;
        logic [INDEX_BITWIDTH-1:0] idx_w;
        logic                      first;
        logic                      last_pair;
        logic                      nop;
        logic                      acc_done;
    } pair_beat_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ACC_COUNT_BITWIDTH-1:0] sat_inc(
        input logic [ACC_COUNT_BITWIDTH-1:0] v
    );
        return (&v) ? v : v + ACC_COUNT_BITWIDTH'(1);
    endfunction

endpackage

// File: rtl/operand_pair_scheduler_lsb_pair_picker.sv
// ----------------------------------------------------------------------------
// operand_pair_scheduler_lsb_pair_picker
// Combinational: picks the lowest set bit p of the remaining mutual mask and
// converts it into dense indices into the activation and weight clusters.
// Ports:
//   i_rem        remaining mutual (A&W) mask
//   i_bitmask_a  activation bitmask
//   i_bitmask_w  weight bitmask
//   o_p          one-hot lowest set bit of i_rem (0 when i_rem is empty)
//   o_idx_a      popcount of i_bitmask_a below p
//   o_idx_w      popcount of i_bitmask_w below p
//   o_rem_next   i_rem with p cleared
//   o_single_bit i_rem has exactly one bit set
// ----------------------------------------------------------------------------
module operand_pair_scheduler_lsb_pair_picker
    import operand_pair_scheduler_pkg::*;
(
    input  logic [BITMASK_LENGTH-1:0] i_rem,
    input  logic [BITMASK_LENGTH-1:0] i_bitmask_a,
    input  logic [BITMASK_LENGTH-1:0] i_bitmask_w,
    output logic [BITMASK_LENGTH-1:0] o_p,
    output logic [INDEX_BITWIDTH-1:0] o_idx_a,
    output logic [INDEX_BITWIDTH-1:0] o_idx_w,
    output logic [BITMASK_LENGTH-1:0] o_rem_next,
    output logic                      o_single_bit
);

    localparam logic [BITMASK_LENGTH-1:0] LsbOne = BITMASK_LENGTH'(1);

    logic [BITMASK_LENGTH-1:0] w_below;

    always_comb begin
        o_p          = i_rem & (~i_rem + LsbOne);
        // Bits strictly below p; forced empty when there is no p so an
        // empty mask yields index 0 rather than a full popcount.
        w_below      = (i_rem == '0) ? '0 : (o_p - LsbOne);
        o_rem_next   = i_rem & ~o_p;
        o_single_bit = (i_rem != '0) && ((i_rem & (i_rem - LsbOne)) == '0);
        o_idx_a      = '0;
        o_idx_w      = '0;
        // p is at most the top bit, so at most BITMASK_LENGTH-1 bits count.
        for (int i = 0; i < BITMASK_LENGTH; i++) begin
            o_idx_a = o_idx_a + INDEX_BITWIDTH'(w_below[i] & i_bitmask_a[i]);
            o_idx_w = o_idx_w + INDEX_BITWIDTH'(w_below[i] & i_bitmask_w[i]);
        end
    end

endmodule

// File: rtl/operand_pair_scheduler.sv
// ----------------------------------------------------------------------------
// operand_pair_scheduler
// Accepts one sparse cluster (weight/activation bitmasks + end-of-dot-product
// flag) per handshake and streams its matched operand pairs, one per cycle,
// as dense indices with first/last/nop/done markers. Keeps a saturating
// per-dot-product pair counter.
// Ports:
//   clock, resetn                 clock, async active-low reset
//   in_valid/in_ready             cluster handshake
//   in_bitmask_w/in_bitmask_a     cluster bitmasks
//   in_last                       cluster ends the dot product
//   out_valid/out_ready           pair beat handshake
//   out_idx_a/out_idx_w           dense indices of the pair
//   out_first/out_last_pair       first/last beat of the cluster
//   out_nop                       beat carries no pair
//   out_acc_done                  last beat of the dot product
//   out_acc_pairs                 real pairs in the dot product (on acc_done)
// ----------------------------------------------------------------------------
module operand_pair_scheduler
    import operand_pair_scheduler_pkg::*;
(
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BITMASK_LENGTH-1:0]     in_bitmask_w,
    input  logic [BITMASK_LENGTH-1:0]     in_bitmask_a,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INDEX_BITWIDTH-1:0]     out_idx_a,
    output logic [INDEX_BITWIDTH-1:0]     out_idx_w,
    output logic                          out_first,
    output logic                          out_last_pair,
    output logic                          out_nop,
    output logic                          out_acc_done,
    output logic [ACC_COUNT_BITWIDTH-1:0] out_acc_pairs
);

    state_t                        r_state, w_state_next;
    logic [BITMASK_LENGTH-1:0]     r_bm_a, w_bm_a_next;
    logic [BITMASK_LENGTH-1:0]     r_bm_w, w_bm_w_next;
    logic [BITMASK_LENGTH-1:0]     r_rem, w_rem_next;
    logic                          r_last, w_last_next;
    logic                          r_first, w_first_next;
    logic [ACC_COUNT_BITWIDTH-1:0] r_cnt, w_cnt_next;

    logic [BITMASK_LENGTH-1:0]     w_pick_p;
    logic [INDEX_BITWIDTH-1:0]     w_pick_idx_a;
    logic [INDEX_BITWIDTH-1:0]     w_pick_idx_w;
    logic [BITMASK_LENGTH-1:0]     w_pick_rem_next;
    logic                          w_pick_single;

    logic                          w_valid;
    logic                          w_out_hs;
    logic                          w_accept;
    logic [BITMASK_LENGTH-1:0]     w_in_rem;
    pair_beat_t                    w_beat;

    operand_pair_scheduler_lsb_pair_picker u_lsb_pair_picker (
        .i_rem        (r_rem),
        .i_bitmask_a  (r_bm_a),
        .i_bitmask_w  (r_bm_w),
        .o_p          (w_pick_p),
        .o_idx_a      (w_pick_idx_a),
        .o_idx_w      (w_pick_idx_w),
        .o_rem_next   (w_pick_rem_next),
        .o_single_bit (w_pick_single)
    );

    // Beat decode; everything is gated by w_valid so IDLE drives zeros even
    // though the mask registers keep stale contents.
    always_comb begin
        w_valid          = (r_state == StIssue);
        w_beat           = '0;
        if (w_valid) begin
            // An ISSUE state with an empty mask is the NOP beat of an empty
            // last cluster.
            w_beat.nop       = (w_pick_p == '0);
            w_beat.idx_a     = w_pick_idx_a;
            w_beat.idx_w     = w_pick_idx_w;
            w_beat.first     = r_first;
            w_beat.last_pair = w_beat.nop | w_pick_single;
            w_beat.acc_done  = w_beat.last_pair & r_last;
        end
        w_out_hs         = w_valid & out_ready;
        in_ready         = resetn & (~w_valid | (out_ready & w_beat.last_pair));
        w_accept         = in_valid & in_ready;
        w_in_rem         = in_bitmask_a & in_bitmask_w;

        out_valid        = w_valid;
        out_idx_a        = w_beat.idx_a;
        out_idx_w        = w_beat.idx_w;
        out_first        = w_beat.first;
        out_last_pair    = w_beat.last_pair;
        out_nop          = w_beat.nop;
        out_acc_done     = w_beat.acc_done;
        // Include the beat on screen so the total is complete at acc_done.
        if (w_beat.acc_done && !w_beat.nop) begin
            out_acc_pairs = sat_inc(r_cnt);
        end else begin
            out_acc_pairs = r_cnt;
        end
    end

    // Next-state: a new cluster load takes priority, which also covers the
    // back-to-back case where it coincides with the last beat handshake.
    always_comb begin
        w_state_next = r_state;
        w_bm_a_next  = r_bm_a;
        w_bm_w_next  = r_bm_w;
        w_rem_next   = r_rem;
        w_last_next  = r_last;
        w_first_next = r_first;
        w_cnt_next   = r_cnt;

        if (w_accept) begin
            w_bm_a_next  = in_bitmask_a;
            w_bm_w_next  = in_bitmask_w;
            w_rem_next   = w_in_rem;
            w_last_next  = in_last;
            w_first_next = 1'b1;
            w_state_next = ((w_in_rem != '0) || in_last) ? StIssue : StIdle;
        end else if (w_out_hs) begin
            w_rem_next   = w_pick_rem_next;
            w_first_next = 1'b0;
            if (w_beat.last_pair) begin
                w_state_next = StIdle;
            end
        end

        if (w_out_hs) begin
            if (w_beat.acc_done) begin
                w_cnt_next = '0;
            end else if (!w_beat.nop) begin
                w_cnt_next = sat_inc(r_cnt);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= StIdle;
            r_bm_a  <= '0;
            r_bm_w  <= '0;
            r_rem   <= '0;
            r_last  <= 1'b0;
            r_first <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_bm_a  <= w_bm_a_next;
            r_bm_w  <= w_bm_w_next;
            r_rem   <= w_rem_next;
            r_last  <= w_last_next;
            r_first <= w_first_next;
            r_cnt   <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_operand_pair_scheduler.sv
// ----------------------------------------------------------------------------
// tb_operand_pair_scheduler
// Directed bench: hand-computed pair streams for several clusters, stall,
// back-to-back, NOP and mid-cluster reset cases.
// ----------------------------------------------------------------------------
module tb_operand_pair_scheduler;

    logic        clock = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_bitmask_w;
    logic [7:0]  in_bitmask_a;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_idx_a;
    logic [2:0]  out_idx_w;
    logic        out_first;
    logic        out_last_pair;
    logic        out_nop;
    logic        out_acc_done;
    logic [15:0] out_acc_pairs;

    int checks = 0;
    int errors = 0;

    operand_pair_scheduler dut (
        .clock         (clock),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_bitmask_w  (in_bitmask_w),
        .in_bitmask_a  (in_bitmask_a),
        .in_last       (in_last),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_idx_a     (out_idx_a),
        .out_idx_w     (out_idx_w),
        .out_first     (out_first),
        .out_last_pair (out_last_pair),
        .out_nop       (out_nop),
        .out_acc_done  (out_acc_done),
        .out_acc_pairs (out_acc_pairs)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full beat check: valid, indices, markers.
    task automatic chk_beat(input string tag, input logic [2:0] a, input logic [2:0] w,
                            input logic first, input logic lastp, input logic nop,
                            input logic done);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".idx_a"}, 32'(out_idx_a), 32'(a));
        chk({tag, ".idx_w"}, 32'(out_idx_w), 32'(w));
        chk({tag, ".first"}, 32'(out_first), 32'(first));
        chk({tag, ".last_pair"}, 32'(out_last_pair), 32'(lastp));
        chk({tag, ".nop"}, 32'(out_nop), 32'(nop));
        chk({tag, ".acc_done"}, 32'(out_acc_done), 32'(done));
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input logic [7:0] a, input logic [7:0] w, input logic last);
        in_valid     = 1'b1;
        in_bitmask_a = a;
        in_bitmask_w = w;
        in_last      = last;
    endtask

    initial begin
        resetn       = 1'b0;
        in_valid     = 1'b0;
        in_bitmask_a = '0;
        in_bitmask_w = '0;
        in_last      = 1'b0;
        out_ready    = 1'b1;
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.acc_pairs", 32'(out_acc_pairs), 32'd0);
        chk("rst.idx_a", 32'(out_idx_a), 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        chk("idle.in_ready", 32'(in_ready), 32'd1);

        // Basic cluster: A&W = bits 2,5,7
        present(8'hF5, 8'hAE, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        chk_beat("t1.b1", 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk_beat("t1.b2", 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_beat("t1.b3", 3'd5, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t1.acc_pairs", 32'(out_acc_pairs), 32'd3);
        chk("t1.in_ready_b3", 32'(in_ready), 32'd1);
        tick();
        chk("t1.idle", 32'(out_valid), 32'd0);

        // Same cluster, beat 2 stalled for 3 cycles
        present(8'hF5, 8'hAE, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        chk_beat("t2.b1", 3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            out_ready = (i == 3);
            #1;
            chk_beat("t2.hold", 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t2.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk_beat("t2.b3", 3'd5, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t2.acc_pairs", 32'(out_acc_pairs), 32'd3);
        tick();

        // Empty non-last cluster discarded, then single-pair last cluster
        present(8'h0F, 8'hF0, 1'b0);
        tick();
        present(8'h01, 8'h01, 1'b1);
        #1;
        chk("t3.no_beat", 32'(out_valid), 32'd0);
        chk("t3.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk_beat("t3.b1", 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3.acc_pairs", 32'(out_acc_pairs), 32'd1);
        tick();
        chk("t3.idle", 32'(out_valid), 32'd0);

        // Empty last cluster: single NOP beat
        present(8'h00, 8'hFF, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        chk_beat("t4.nop", 3'd0, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4.acc_pairs", 32'(out_acc_pairs), 32'd0);
        tick();
        chk("t4.idle", 32'(out_valid), 32'd0);

        // Back-to-back full clusters, 16 beats without a bubble
        present(8'hFF, 8'hFF, 1'b0);
        tick();
        present(8'hFF, 8'hFF, 1'b1);
        for (int b = 0; b < 16; b++) begin
            #1;
            chk_beat("t5.beat", 3'(b % 8), 3'(b % 8), (b % 8) == 0, (b % 8) == 7, 1'b0,
                     b == 15);
            chk("t5.in_ready", 32'(in_ready), 32'((b % 8) == 7));
            if (b == 15) begin
                chk("t5.acc_pairs", 32'(out_acc_pairs), 32'd16);
            end
            tick();
            if (b == 7) begin
                in_valid = 1'b0;
            end
        end
        chk("t5.idle", 32'(out_valid), 32'd0);

        // Reset in the middle of a cluster
        present(8'hFF, 8'hFF, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk_beat("t6.b4", 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        chk("t6.rst_valid", 32'(out_valid), 32'd0);
        chk("t6.rst_in_ready", 32'(in_ready), 32'd0);
        tick();
        resetn = 1'b1;
        #1;
        chk("t6.post_valid", 32'(out_valid), 32'd0);
        chk("t6.post_in_ready", 32'(in_ready), 32'd1);
        chk("t6.post_acc_pairs", 32'(out_acc_pairs), 32'd0);
        tick();
        chk("t6.no_residual", 32'(out_valid), 32'd0);
        tick();
        chk("t6.no_residual2", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
